// File: rtl/usb_pkg.sv
// Shared definitions for the USB host transaction layer: sequencer states,
// sender strobe encoding and default retry/timeout settings.
package usb_pkg;

  localparam int DEFAULT_MAX_ATTEMPTS   = 8;
  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  typedef enum logic [3:0] {
    IDLE,
    SEND_TOK,
    WAIT_TOK,
    SEND_DATA,
    WAIT_DATA,
    WAIT_HS,
    WAIT_RX,
    SEND_HS,
    WAIT_HS_DONE,
    RETRY,
    DONE
  } txn_state_t;

  // A single encoded strobe register guarantees at most one sender strobe per cycle.
  typedef enum logic [2:0] {
    STB_NONE,
    STB_OUT,
    STB_IN,
    STB_DATA0,
    STB_ACK,
    STB_NAK
  } strobe_t;

endpackage

// File: rtl/txn_timer.sv
// Turnaround timer: counts cycles while enabled and flags the final cycle of
// the TIMEOUT_CYCLES-long response window.
module txn_timer
  import usb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign timeout = enable && (count == LAST);

endmodule

// File: rtl/usb_txn_sequencer.sv
// Host-side OUT/IN transaction sequencer: drives the packet sender strobes,
// arms the receiver, and applies the retry and turnaround-timeout policy.
module usb_txn_sequencer
  import usb_pkg::*;
#(
  parameter int MAX_ATTEMPTS   = DEFAULT_MAX_ATTEMPTS,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        txn_start,
  input  logic        txn_is_in,
  input  logic [3:0]  txn_endp,
  input  logic [63:0] txn_data_out,
  output logic        txn_busy,
  output logic        txn_done,
  output logic        txn_success,
  output logic [63:0] txn_data_in,
  output logic        send_OUT,
  output logic        send_IN,
  output logic        send_DATA0,
  output logic        send_ACK,
  output logic        send_NAK,
  output logic [3:0]  endp,
  output logic [63:0] data,
  input  logic        out_done,
  output logic        rx_enable,
  input  logic        rx_ack,
  input  logic        rx_nak,
  input  logic        rx_data_valid,
  input  logic        rx_data_ok,
  input  logic [63:0] rx_data
);

  localparam int AW = $clog2(MAX_ATTEMPTS + 1);
  localparam logic [AW-1:0] LAST_ATTEMPT = AW'(MAX_ATTEMPTS);

  txn_state_t    state, next_state;
  strobe_t       strobe_q, next_strobe;
  logic [AW-1:0] attempt_q;
  logic [AW-1:0] attempt_inc;
  logic          is_in_q;
  logic          hs_is_ack_q;
  logic          done_ok;
  logic          in_wait;
  logic          timeout;

  assign in_wait     = (state == WAIT_HS) || (state == WAIT_RX);
  assign attempt_inc = attempt_q + 1'b1;

  txn_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (!in_wait),
    .enable  (in_wait),
    .timeout (timeout)
  );

  // NOTE: every signal gets a default before the case so no path infers a latch.
  always_comb begin
    next_state  = state;
    next_strobe = STB_NONE;
    done_ok     = 1'b0;
    unique case (state)
      IDLE:         if (txn_start) next_state = SEND_TOK;
      SEND_TOK: begin
        next_strobe = is_in_q ? STB_IN : STB_OUT;
        next_state  = WAIT_TOK;
      end
      WAIT_TOK:     if (out_done) next_state = is_in_q ? WAIT_RX : SEND_DATA;
      SEND_DATA: begin
        next_strobe = STB_DATA0;
        next_state  = WAIT_DATA;
      end
      WAIT_DATA:    if (out_done) next_state = WAIT_HS;
      WAIT_HS: begin
        // NAK dominates a simultaneous ACK; any rx event beats the timeout.
        if (rx_nak) begin
          next_state = RETRY;
        end else if (rx_ack) begin
          next_state = DONE;
          done_ok    = 1'b1;
        end else if (timeout) begin
          next_state = RETRY;
        end
      end
      WAIT_RX: begin
        if (rx_data_valid)  next_state = SEND_HS;
        else if (timeout)   next_state = RETRY;
      end
      SEND_HS: begin
        next_strobe = hs_is_ack_q ? STB_ACK : STB_NAK;
        next_state  = WAIT_HS_DONE;
      end
      WAIT_HS_DONE: begin
        if (out_done) begin
          next_state = hs_is_ack_q ? DONE : RETRY;
          done_ok    = hs_is_ack_q;
        end
      end
      RETRY:        next_state = (attempt_inc == LAST_ATTEMPT) ? DONE : SEND_TOK;
      DONE:         next_state = IDLE;
      default:      next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      strobe_q    <= STB_NONE;
      attempt_q   <= '0;
      is_in_q     <= 1'b0;
      hs_is_ack_q <= 1'b0;
      txn_busy    <= 1'b0;
      txn_done    <= 1'b0;
      txn_success <= 1'b0;
      txn_data_in <= '0;
      rx_enable   <= 1'b0;
      endp        <= '0;
      data        <= '0;
    end else begin
      state       <= next_state;
      strobe_q    <= next_strobe;
      txn_busy    <= (next_state != IDLE);
      txn_done    <= (next_state == DONE);
      txn_success <= (next_state == DONE) && done_ok;
      rx_enable   <= (next_state == WAIT_HS) || (next_state == WAIT_RX);
      if (state == IDLE && txn_start) begin
        is_in_q   <= txn_is_in;
        endp      <= txn_endp;
        data      <= txn_data_out;
        attempt_q <= '0;
      end
      if (state == RETRY) attempt_q <= attempt_inc;
      if (state == WAIT_RX && rx_data_valid) begin
        hs_is_ack_q <= rx_data_ok;
        if (rx_data_ok) txn_data_in <= rx_data;
      end
    end
  end

  assign send_OUT   = (strobe_q == STB_OUT);
  assign send_IN    = (strobe_q == STB_IN);
  assign send_DATA0 = (strobe_q == STB_DATA0);
  assign send_ACK   = (strobe_q == STB_ACK);
  assign send_NAK   = (strobe_q == STB_NAK);

endmodule

// File: tb/tb_usb_txn_sequencer.sv
// Directed self-checking bench for usb_txn_sequencer with a simple sender
// model answering every strobe with out_done ten cycles later.
module tb_usb_txn_sequencer;

  localparam int SENDER_DELAY = 10;
  localparam logic [63:0] PAY_A  = 64'hDEAD_BEEF_0123_4567;
  localparam logic [63:0] PAY_B  = 64'h0F0F_0F0F_A5A5_A5A5;
  localparam logic [63:0] PAY_IN = 64'h1122_3344_5566_7788;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        txn_start = 1'b0;
  logic        txn_is_in = 1'b0;
  logic [3:0]  txn_endp = '0;
  logic [63:0] txn_data_out = '0;
  logic        txn_busy, txn_done, txn_success;
  logic [63:0] txn_data_in;
  logic        send_OUT, send_IN, send_DATA0, send_ACK, send_NAK;
  logic [3:0]  endp;
  logic [63:0] data;
  logic        out_done = 1'b0;
  logic        rx_enable;
  logic        rx_ack = 1'b0;
  logic        rx_nak = 1'b0;
  logic        rx_data_valid = 1'b0;
  logic        rx_data_ok = 1'b0;
  logic [63:0] rx_data = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt_out = 0, cnt_in = 0, cnt_d0 = 0, cnt_ack = 0, cnt_nak = 0, cnt_multi = 0;
  int b_out, b_in, b_d0, b_ack, b_nak;

  usb_txn_sequencer dut (
    .clock         (clock),
    .reset         (reset),
    .txn_start     (txn_start),
    .txn_is_in     (txn_is_in),
    .txn_endp      (txn_endp),
    .txn_data_out  (txn_data_out),
    .txn_busy      (txn_busy),
    .txn_done      (txn_done),
    .txn_success   (txn_success),
    .txn_data_in   (txn_data_in),
    .send_OUT      (send_OUT),
    .send_IN       (send_IN),
    .send_DATA0    (send_DATA0),
    .send_ACK      (send_ACK),
    .send_NAK      (send_NAK),
    .endp          (endp),
    .data          (data),
    .out_done      (out_done),
    .rx_enable     (rx_enable),
    .rx_ack        (rx_ack),
    .rx_nak        (rx_nak),
    .rx_data_valid (rx_data_valid),
    .rx_data_ok    (rx_data_ok),
    .rx_data       (rx_data)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Strobe monitor: tallies each strobe and any cycle with more than one high.
  initial forever begin
    @(negedge clock);
    cnt_out += int'(send_OUT);
    cnt_in  += int'(send_IN);
    cnt_d0  += int'(send_DATA0);
    cnt_ack += int'(send_ACK);
    cnt_nak += int'(send_NAK);
    if ((int'(send_OUT) + int'(send_IN) + int'(send_DATA0) + int'(send_ACK) + int'(send_NAK)) > 1)
      cnt_multi++;
  end

  // Sender model: completes each packet SENDER_DELAY cycles after its strobe.
  initial forever begin
    @(negedge clock);
    if (send_OUT || send_IN || send_DATA0 || send_ACK || send_NAK) begin
      repeat (SENDER_DELAY) @(negedge clock);
      out_done = 1'b1;
      @(negedge clock);
      out_done = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic snap();
    b_out = cnt_out; b_in = cnt_in; b_d0 = cnt_d0; b_ack = cnt_ack; b_nak = cnt_nak;
  endtask

  task automatic start_txn(input logic is_in, input logic [3:0] ep, input logic [63:0] pay);
    txn_start = 1'b1; txn_is_in = is_in; txn_endp = ep; txn_data_out = pay;
    @(negedge clock);
    txn_start = 1'b0; txn_is_in = 1'b0; txn_endp = '0; txn_data_out = '0;
  endtask

  task automatic wait_rx_en(input int max, output bit found);
    found = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (rx_enable) begin found = 1'b1; break; end
      @(negedge clock);
    end
  endtask

  task automatic wait_done(input int max, output bit found, output int cycles);
    found = 1'b0; cycles = 0;
    for (int i = 0; i < max; i++) begin
      if (txn_done) begin found = 1'b1; cycles = i; break; end
      @(negedge clock);
    end
  endtask

  initial begin
    bit f;
    int c, len, n_done, n_busy;

    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("rst_busy",    txn_busy, 0);
    check("rst_done",    txn_done, 0);
    check("rst_success", txn_success, 0);
    check("rst_data_in", txn_data_in, 0);
    check("rst_endp",    endp, 0);
    check("rst_data",    data, 0);
    check("rst_rx_en",   rx_enable, 0);

    // Clean OUT, ACK five cycles into the handshake window.
    snap();
    start_txn(1'b0, 4'd4, PAY_A);
    check("t1_busy_rise", txn_busy, 1);
    wait_rx_en(100, f);
    check("t1_hs_seen", f, 1);
    check("t1_endp", endp, 4);
    check("t1_data", data, PAY_A);
    repeat (4) @(negedge clock);
    rx_ack = 1'b1;
    @(negedge clock);
    rx_ack = 1'b0;
    wait_done(5, f, c);
    check("t1_done", f, 1);
    check("t1_done_lat", c, 0);
    check("t1_success", txn_success, 1);
    check("t1_n_out", cnt_out - b_out, 1);
    check("t1_n_d0", cnt_d0 - b_d0, 1);
    check("t1_n_in", cnt_in - b_in, 0);
    @(negedge clock);
    check("t1_done_pulse", txn_done, 0);
    check("t1_busy_fall", txn_busy, 0);

    // OUT: NAK, NAK together with ACK, then ACK.
    snap();
    start_txn(1'b0, 4'd1, PAY_B);
    for (int k = 0; k < 3; k++) begin
      wait_rx_en(100, f);
      check($sformatf("t2_hs_seen%0d", k), f, 1);
      repeat (2) @(negedge clock);
      rx_nak = (k < 2);
      rx_ack = (k > 0);
      @(negedge clock);
      rx_nak = 1'b0; rx_ack = 1'b0;
    end
    wait_done(5, f, c);
    check("t2_done", f, 1);
    check("t2_success", txn_success, 1);
    check("t2_n_out", cnt_out - b_out, 3);
    check("t2_n_d0", cnt_d0 - b_d0, 3);
    @(negedge clock);

    // IN with good data.
    snap();
    start_txn(1'b1, 4'd2, '0);
    wait_rx_en(100, f);
    check("t3_rx_seen", f, 1);
    repeat (3) @(negedge clock);
    rx_data_valid = 1'b1; rx_data_ok = 1'b1; rx_data = PAY_IN;
    @(negedge clock);
    rx_data_valid = 1'b0; rx_data_ok = 1'b0; rx_data = '0;
    check("t3_rx_off", rx_enable, 0);
    wait_done(40, f, c);
    check("t3_done", f, 1);
    check("t3_success", txn_success, 1);
    check("t3_data_in", txn_data_in, PAY_IN);
    check("t3_n_in", cnt_in - b_in, 1);
    check("t3_n_ack", cnt_ack - b_ack, 1);
    check("t3_n_nak", cnt_nak - b_nak, 0);
    check("t3_n_out", cnt_out - b_out, 0);
    @(negedge clock);

    // IN with corrupt data on every attempt.
    snap();
    start_txn(1'b1, 4'd3, '0);
    for (int k = 0; k < 8; k++) begin
      wait_rx_en(100, f);
      check($sformatf("t4_rx_seen%0d", k), f, 1);
      @(negedge clock);
      rx_data_valid = 1'b1; rx_data_ok = 1'b0; rx_data = 64'hBAD0_BAD0_BAD0_BAD0;
      @(negedge clock);
      rx_data_valid = 1'b0; rx_data = '0;
    end
    wait_done(40, f, c);
    check("t4_done", f, 1);
    check("t4_success", txn_success, 0);
    check("t4_data_in", txn_data_in, PAY_IN);
    check("t4_n_nak", cnt_nak - b_nak, 8);
    check("t4_n_in", cnt_in - b_in, 8);
    check("t4_n_ack", cnt_ack - b_ack, 0);
    @(negedge clock);

    // OUT with no response: every window times out.
    snap();
    start_txn(1'b0, 4'd5, PAY_A);
    for (int k = 0; k < 8; k++) begin
      wait_rx_en(100, f);
      check($sformatf("t5_hs_seen%0d", k), f, 1);
      len = 0;
      while (rx_enable && len < 400) begin
        len++;
        @(negedge clock);
      end
      check($sformatf("t5_hs_len%0d", k), len, 255);
    end
    wait_done(5, f, c);
    check("t5_done", f, 1);
    check("t5_success", txn_success, 0);
    check("t5_n_out", cnt_out - b_out, 8);
    check("t5_n_d0", cnt_d0 - b_d0, 8);
    @(negedge clock);

    // ACK arriving on the timeout cycle wins.
    snap();
    start_txn(1'b0, 4'd6, PAY_B);
    wait_rx_en(100, f);
    check("t6_hs_seen", f, 1);
    repeat (254) @(negedge clock);
    rx_ack = 1'b1;
    @(negedge clock);
    rx_ack = 1'b0;
    wait_done(5, f, c);
    check("t6_done", f, 1);
    check("t6_done_lat", c, 0);
    check("t6_success", txn_success, 1);
    check("t6_n_out", cnt_out - b_out, 1);
    @(negedge clock);

    // txn_start while busy is ignored.
    snap();
    start_txn(1'b0, 4'd4, PAY_A);
    wait_rx_en(100, f);
    check("t7_hs_seen", f, 1);
    start_txn(1'b1, 4'd9, PAY_B);
    check("t7_endp_hold", endp, 4);
    check("t7_data_hold", data, PAY_A);
    check("t7_still_hs", rx_enable, 1);
    rx_ack = 1'b1;
    @(negedge clock);
    rx_ack = 1'b0;
    wait_done(5, f, c);
    check("t7_done", f, 1);
    check("t7_success", txn_success, 1);
    check("t7_n_in", cnt_in - b_in, 0);
    check("t7_n_out", cnt_out - b_out, 1);
    repeat (2) @(negedge clock);
    check("t7_idle_after", txn_busy, 0);

    // Reset asserted while waiting for DATA0 completion.
    start_txn(1'b0, 4'd7, PAY_B);
    f = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (send_DATA0) begin f = 1'b1; break; end
      @(negedge clock);
    end
    check("t8_d0_seen", f, 1);
    reset = 1'b1;
    @(negedge clock);
    check("t8_busy", txn_busy, 0);
    check("t8_done", txn_done, 0);
    check("t8_rx_en", rx_enable, 0);
    check("t8_strobes", {send_OUT, send_IN, send_DATA0, send_ACK, send_NAK}, 0);
    check("t8_endp", endp, 0);
    check("t8_data", data, 0);
    check("t8_data_in", txn_data_in, 0);
    reset = 1'b0;
    snap();
    n_done = 0; n_busy = 0;
    repeat (15) begin
      @(negedge clock);
      n_done += int'(txn_done);
      n_busy += int'(txn_busy);
    end
    check("t8_no_done", n_done, 0);
    check("t8_stay_idle", n_busy, 0);
    check("t8_no_strobes", (cnt_out - b_out) + (cnt_d0 - b_d0) + (cnt_in - b_in), 0);

    check("strobe_onehot", cnt_multi, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
